// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-side responder for the MFA/MFC handshake.
// Captures a request from the control unit and waits WAIT_CYCLES cycles.
// It then performs a word (big-endian) or byte access on a byte-addressed RAM.
// MFC is raised on completion and held until MFA drops.
//
// Handshake: a request is captured on the first posedge in IDLE with MFA=1.
// MFA must stay high until MFC is seen. Dropping MFA before completion aborts
// the request with no side effects. After completion MFC stays high while MFA
// is high. The first posedge with MFA=0 returns the unit to IDLE.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN adds the Fault output. With it,
// misaligned word accesses complete with Fault=1 and DataOut=0, and do not
// write the RAM.
// state_dbg exposes the FSM state: 0=IDLE, 1=WAIT, 2=DONE.
module mem_access_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  MFA,
    input  logic                  READ_WRITE,
    input  logic                  WORD_BYTE,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MFC,
    output logic                  Busy,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                  Fault,
`endif
    output logic [1:0]            state_dbg
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_din;
    logic                  lat_rd;
    logic                  lat_word;
    logic                  capture;
    logic                  access;
    logic                  misalign;
    logic                  mem_we;
    logic [31:0]           rd_data;
    logic [ADDR_WIDTH-3:0] word_idx;

    logic [7:0] mem [0:DEPTH-1];

    assign Busy      = (state != S_IDLE);
    assign state_dbg = 2'(state);
    assign word_idx  = lat_addr[ADDR_WIDTH-1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = lat_word && (lat_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign mem_we = access && !lat_rd && !misalign;

    // Read data: big-endian word from the aligned base, or zero-extended byte.
    always_comb begin
        rd_data = 32'h0;
        if (lat_word) begin
            rd_data = {mem[{word_idx, 2'b00}], mem[{word_idx, 2'b01}],
                       mem[{word_idx, 2'b10}], mem[{word_idx, 2'b11}]};
        end else begin
            rd_data = {24'h0, mem[lat_addr]};
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and the capture/access strobes.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        access    = 1'b0;
        case (state)
            S_IDLE: begin
                if (MFA) begin
                    capture   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!MFA) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!MFA) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, wait counter and the MFC/DataOut outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= 4'd0;
            lat_addr <= '0;
            lat_din  <= 32'h0;
            lat_rd   <= 1'b0;
            lat_word <= 1'b0;
            MFC      <= 1'b0;
            DataOut  <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
            Fault    <= 1'b0;
`endif
        end else begin
            if (capture) begin
                lat_addr <= Address;
                lat_din  <= DataIn;
                lat_rd   <= READ_WRITE;
                lat_word <= WORD_BYTE;
                cnt      <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT && MFA && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (access) begin
                MFC <= 1'b1;
                if (misalign)    DataOut <= 32'h0;
                else if (lat_rd) DataOut <= rd_data;
`ifdef MEM_MISALIGN_TRAP_EN
                Fault <= misalign;
`endif
            end else if (state == S_DONE && !MFA) begin
                MFC <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                Fault <= 1'b0;
`endif
            end
        end
    end

    // RAM write port (contents are not reset).
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            if (lat_word) begin
                mem[{word_idx, 2'b00}] <= lat_din[31:24];
                mem[{word_idx, 2'b01}] <= lat_din[23:16];
                mem[{word_idx, 2'b10}] <= lat_din[15:8];
                mem[{word_idx, 2'b11}] <= lat_din[7:0];
            end else begin
                mem[lat_addr] <= lat_din[7:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit.
// The main instance has WAIT_CYCLES=2. Two extra instances, with WAIT_CYCLES
// of 0 and 5, cover the latency sweep.
module tb_mem_access_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        mfa, rw, wb;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        mfc, busy;
    logic [1:0]  st;

    logic        mfa0, mfa5;
    logic [31:0] dout0, dout5;
    logic        mfc0, mfc5, busy0, busy5;
    logic [1:0]  st0, st5;

`ifdef MEM_MISALIGN_TRAP_EN
    logic fault, fault0, fault5;
`endif
    logic exp_fault;

    mem_access_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
        .Clk(clk), .Reset(reset), .MFA(mfa), .READ_WRITE(rw), .WORD_BYTE(wb),
        .Address(addr), .DataIn(din), .DataOut(dout), .MFC(mfc), .Busy(busy),
`ifdef MEM_MISALIGN_TRAP_EN
        .Fault(fault),
`endif
        .state_dbg(st)
    );

    mem_access_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
        .Clk(clk), .Reset(reset), .MFA(mfa0), .READ_WRITE(rw), .WORD_BYTE(wb),
        .Address(addr), .DataIn(din), .DataOut(dout0), .MFC(mfc0), .Busy(busy0),
`ifdef MEM_MISALIGN_TRAP_EN
        .Fault(fault0),
`endif
        .state_dbg(st0)
    );

    mem_access_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(5)) u_w5 (
        .Clk(clk), .Reset(reset), .MFA(mfa5), .READ_WRITE(rw), .WORD_BYTE(wb),
        .Address(addr), .DataIn(din), .DataOut(dout5), .MFC(mfc5), .Busy(busy5),
`ifdef MEM_MISALIGN_TRAP_EN
        .Fault(fault5),
`endif
        .state_dbg(st5)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rd;
        logic        word;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[11];

    // ---------------- driver ----------------
    // One full transaction on the main instance. Address and DataIn are
    // scrambled right after capture to show that the request is latched.
    task automatic do_txn(input string nm, input logic r, input logic w,
                          input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
        int  edges;
        bit  seen;
        @(negedge clk);
        rw = r; wb = w; addr = a; din = d; mfa = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                din  = ~d;
                addr = ~a;
            end
            if (mfc === 1'b1) seen = 1'b1;
        end
        check32({nm, "_latency"}, 32'(edges), 32'd4);
        check32({nm, "_mfc"}, {31'b0, mfc}, 32'd1);
        check32({nm, "_busy"}, {31'b0, busy}, 32'd1);
        check32({nm, "_dout"}, dout, exp);
`ifdef MEM_MISALIGN_TRAP_EN
        check32({nm, "_fault"}, {31'b0, fault}, {31'b0, exp_fault});
`endif
        @(negedge clk);
        mfa = 1'b0;
        @(posedge clk);
        #1;
        check32({nm, "_mfc_drop"}, {31'b0, mfc}, 32'd0);
        check32({nm, "_busy_drop"}, {31'b0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first0, first5, e;
        bit any_mfc;

        vecs[0]  = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b1, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 8'h10, 32'h0,        32'h000000DE};
        vecs[3]  = '{1'b1, 1'b0, 8'h13, 32'h0,        32'h000000EF};
        vecs[4]  = '{1'b0, 1'b1, 8'h20, 32'h11223344, 32'h000000EF};
        vecs[5]  = '{1'b0, 1'b0, 8'h21, 32'hFFFFFF5A, 32'h000000EF};
        vecs[6]  = '{1'b1, 1'b1, 8'h20, 32'h0,        32'h115A3344};
        vecs[7]  = '{1'b0, 1'b1, 8'hFC, 32'h01020304, 32'h115A3344};
        vecs[8]  = '{1'b1, 1'b1, 8'hFC, 32'h0,        32'h01020304};
        vecs[9]  = '{1'b1, 1'b0, 8'hFF, 32'h0,        32'h00000004};
        vecs[10] = '{1'b0, 1'b1, 8'h40, 32'h0A0B0C0D, 32'h00000004};

        exp_fault = 1'b0;
        reset = 1'b1;
        mfa = 1'b0; mfa0 = 1'b0; mfa5 = 1'b0;
        rw = 1'b1; wb = 1'b1; addr = 8'h0; din = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_mfc", {31'b0, mfc}, 32'd0);
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_dout", dout, 32'h0);
        check32("reset_state", {30'b0, st}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven transactions.
        for (int i = 0; i < 11; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].word,
                   vecs[i].a, vecs[i].d, vecs[i].exp_dout);
        end

        // Latency sweep on the WAIT_CYCLES=0 and =5 instances.
        @(negedge clk);
        rw = 1'b1; wb = 1'b1; addr = 8'h00;
        mfa0 = 1'b1; mfa5 = 1'b1;
        first0 = 0; first5 = 0;
        for (e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (mfc0 === 1'b1 && first0 == 0) first0 = e;
            if (mfc5 === 1'b1 && first5 == 0) first5 = e;
        end
        check32("lat_w0", 32'(first0), 32'd2);
        check32("lat_w5", 32'(first5), 32'd7);
        @(negedge clk);
        mfa0 = 1'b0; mfa5 = 1'b0;
        @(posedge clk);
        #1;
        check32("w0_mfc_drop", {31'b0, mfc0}, 32'd0);
        check32("w5_mfc_drop", {31'b0, mfc5}, 32'd0);
        check32("w5_busy_drop", {31'b0, busy5}, 32'd0);

        // Abort: MFA drops during WAIT of a write.
        @(negedge clk);
        rw = 1'b0; wb = 1'b1; addr = 8'h40; din = 32'hCAFEF00D; mfa = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mfa = 1'b0;
        any_mfc = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (mfc !== 1'b0) any_mfc = 1'b1;
        end
        check32("abort_mfc", {31'b0, any_mfc}, 32'd0);
        check32("abort_busy", {31'b0, busy}, 32'd0);
        check32("abort_dout", dout, 32'h00000004);
        do_txn("abort_readback", 1'b1, 1'b1, 8'h40, 32'h0, 32'h0A0B0C0D);

        // Stall: MFA held high for 10 cycles after MFC.
        @(negedge clk);
        rw = 1'b1; wb = 1'b1; addr = 8'h10; mfa = 1'b1;
        e = 0;
        while (mfc !== 1'b1 && e < 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        check32("stall_mfc_up", {31'b0, mfc}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check32($sformatf("stall%0d_mfc", k), {31'b0, mfc}, 32'd1);
            check32($sformatf("stall%0d_dout", k), dout, 32'hDEADBEEF);
            check32($sformatf("stall%0d_state", k), {30'b0, st}, 32'd2);
        end
        @(negedge clk);
        mfa = 1'b0;
        @(posedge clk);
        #1;
        check32("stall_mfc_drop", {31'b0, mfc}, 32'd0);
        check32("stall_busy_drop", {31'b0, busy}, 32'd0);

        // Reset asserted while in DONE.
        @(negedge clk);
        rw = 1'b1; wb = 1'b1; addr = 8'h20; mfa = 1'b1;
        e = 0;
        while (mfc !== 1'b1 && e < 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        check32("rst_done_pre_dout", dout, 32'h115A3344);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check32("rst_done_mfc", {31'b0, mfc}, 32'd0);
        check32("rst_done_dout", dout, 32'h0);
        check32("rst_done_state", {30'b0, st}, 32'd0);
        check32("rst_done_busy", {31'b0, busy}, 32'd0);
        mfa = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Misaligned word write at 0x42.
`ifdef MEM_MISALIGN_TRAP_EN
        exp_fault = 1'b1;
        do_txn("misalign_wr", 1'b0, 1'b1, 8'h42, 32'h55667788, 32'h0);
        exp_fault = 1'b0;
        do_txn("misalign_rb", 1'b1, 1'b1, 8'h40, 32'h0, 32'h0A0B0C0D);
`else
        do_txn("misalign_wr", 1'b0, 1'b1, 8'h42, 32'h55667788, 32'h0);
        do_txn("misalign_rb", 1'b1, 1'b1, 8'h40, 32'h0, 32'h55667788);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
